// File: rtl/fb_pkg.sv
// Shared definitions for the frame-buffer swap controller:
// default frame geometry, address width and the controller state type.
package fb_pkg;

  localparam int FB_W_DEF  = 640;
  localparam int FB_H_DEF  = 480;
  localparam int FB_ADDR_W = 19;

  typedef enum logic [1:0] {
    CLEAR,
    DRAW,
    WAIT_SWAP,
    SWAP
  } fb_state_t;

endpackage

// File: rtl/fb_addr_gen.sv
// Combinational pixel address generator: addr = y*FB_W + x, truncated
// to FB_ADDR_W bits, plus a flag telling whether (x, y) lies on screen.
// For the 640-column frame the multiply becomes two shifts and an add.
module fb_addr_gen
  import fb_pkg::*;
#(
  parameter int FB_W = FB_W_DEF,
  parameter int FB_H = FB_H_DEF
) (
  input  logic signed [10:0]          x,
  input  logic signed [10:0]          y,
  output logic        [FB_ADDR_W-1:0] addr,
  output logic                        in_bounds
);

  logic [FB_ADDR_W-1:0] x_ext;
  logic [FB_ADDR_W-1:0] y_ext;

  // Sign-extend so negative coordinates wrap modulo 2^FB_ADDR_W.
  assign x_ext = {{(FB_ADDR_W-11){x[10]}}, x};
  assign y_ext = {{(FB_ADDR_W-11){y[10]}}, y};

  generate
    if (FB_W == 640) begin : g_w640
      // 640 = 512 + 128
      assign addr = (y_ext << 9) + (y_ext << 7) + x_ext;
    end else begin : g_wgen
      assign addr = y_ext * FB_ADDR_W'(FB_W) + x_ext;
    end
  endgenerate

  assign in_bounds = !x[10] && !y[10] && (int'(x) < FB_W) && (int'(y) < FB_H);

endmodule

// File: rtl/fb_swap_ctrl.sv
// Double-buffer controller: clears the back buffer, accepts drawer
// pixel writes into it, then swaps buffers on the next frame_start.
// Optional macro FB_DROP_CNT_EN enables the missed-swap counter on
// drop_cnt; without it drop_cnt is tied to zero.
//
// state     | meaning
// ----------+----------------------------------------------------
// CLEAR     | back buffer being zeroed, one address per cycle
// DRAW      | drawer requests accepted and written to back buffer
// WAIT_SWAP | frame finished, waiting for frame_start (vblank)
// SWAP      | one cycle: display_sel toggles, clear restarts at 0
module fb_swap_ctrl
  import fb_pkg::*;
#(
  parameter int FB_W = FB_W_DEF,
  parameter int FB_H = FB_H_DEF
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        frame_start,
  input  logic                        draw_req,
  input  logic signed [10:0]          draw_x,
  input  logic signed [10:0]          draw_y,
  input  logic                        draw_color,
  input  logic                        draw_done,
  output logic                        draw_ack,
  output logic        [FB_ADDR_W-1:0] wr_addr,
  output logic                        wr_data,
  output logic                        wr_en_fb1,
  output logic                        wr_en_fb2,
  output logic                        display_sel,
  output logic        [7:0]           drop_cnt
);

  localparam logic [FB_ADDR_W-1:0] CLR_LAST = FB_ADDR_W'(FB_W * FB_H - 1);

  fb_state_t            state_q, state_d;
  logic [FB_ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [FB_ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic                 wr_data_q, wr_data_d;
  logic                 en1_q, en1_d;
  logic                 en2_q, en2_d;
  logic                 sel_q, sel_d;
  logic                 back_we;
  logic                 accept;
  logic [FB_ADDR_W-1:0] pix_addr;
  logic                 pix_in_bounds;

  fb_addr_gen #(
    .FB_W (FB_W),
    .FB_H (FB_H)
  ) u_addr_gen (
    .x         (draw_x),
    .y         (draw_y),
    .addr      (pix_addr),
    .in_bounds (pix_in_bounds)
  );

  assign accept   = draw_req && (state_q == DRAW);
  assign draw_ack = accept;

  // Next-state and registered-write decode; writes always target the
  // buffer that is not on screen.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    sel_d     = sel_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    back_we   = 1'b0;
    case (state_q)
      CLEAR: begin
        back_we   = 1'b1;
        wr_addr_d = clr_cnt_q;
        wr_data_d = 1'b0;
        if (clr_cnt_q == CLR_LAST) begin
          clr_cnt_d = '0;
          state_d   = DRAW;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      DRAW: begin
        // Off-screen requests are acknowledged but never written.
        if (accept && pix_in_bounds) begin
          back_we   = 1'b1;
          wr_addr_d = pix_addr;
          wr_data_d = draw_color;
        end
        if (draw_done) state_d = WAIT_SWAP;
      end
      WAIT_SWAP: begin
        if (frame_start) state_d = SWAP;
      end
      SWAP: begin
        sel_d     = ~sel_q;
        clr_cnt_d = '0;
        state_d   = CLEAR;
      end
      default: begin
        clr_cnt_d = '0;
        state_d   = CLEAR;
      end
    endcase
    en1_d = back_we & sel_q;
    en2_d = back_we & ~sel_q;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
      sel_q     <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= 1'b0;
      en1_q     <= 1'b0;
      en2_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      sel_q     <= sel_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      en1_q     <= en1_d;
      en2_q     <= en2_d;
    end
  end

  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign wr_en_fb1   = en1_q;
  assign wr_en_fb2   = en2_q;
  assign display_sel = sel_q;

`ifdef FB_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  // Count frame_start pulses that arrive before the frame is ready to swap.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (frame_start && (state_q == CLEAR || state_q == DRAW) && (drop_cnt_q != 8'hFF))
      drop_cnt_d = drop_cnt_q + 8'd1;
  end

  // Missed-swap counter register.
  always_ff @(posedge clk) begin
    if (!reset_n) drop_cnt_q <= 8'd0;
    else          drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`else
  assign drop_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_fb_swap_ctrl.sv
// Self-checking bench for fb_swap_ctrl. Uses a 640x8 instance so a full
// clear pass takes 5120 cycles. A behavioural model predicts every
// cycle's outputs; table vectors and directed sequences add explicit checks.
module tb_fb_swap_ctrl;

  localparam int W   = 640;
  localparam int H   = 8;
  localparam int PIX = W * H;

`ifdef FB_DROP_CNT_EN
  localparam int DROP3   = 3;
  localparam int DROPSAT = 255;
`else
  localparam int DROP3   = 0;
  localparam int DROPSAT = 0;
`endif

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               frame_start = 1'b0;
  logic               draw_req = 1'b0;
  logic signed [10:0] draw_x = '0;
  logic signed [10:0] draw_y = '0;
  logic               draw_color = 1'b0;
  logic               draw_done = 1'b0;
  logic               draw_ack;
  logic [18:0]        wr_addr;
  logic               wr_data;
  logic               wr_en_fb1;
  logic               wr_en_fb2;
  logic               display_sel;
  logic [7:0]         drop_cnt;

  always #5 clk = ~clk;

  fb_swap_ctrl #(.FB_W(W), .FB_H(H)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .frame_start (frame_start),
    .draw_req    (draw_req),
    .draw_x      (draw_x),
    .draw_y      (draw_y),
    .draw_color  (draw_color),
    .draw_done   (draw_done),
    .draw_ack    (draw_ack),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_en_fb1   (wr_en_fb1),
    .wr_en_fb2   (wr_en_fb2),
    .display_sel (display_sel),
    .drop_cnt    (drop_cnt)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int PH_CLEAR = 0, PH_DRAW = 1, PH_WAIT = 2, PH_SWAP = 3;
  int   m_phase;
  int   m_clr;
  bit   m_sel;
  int   m_drop;
  bit   m_valid = 1'b0;
  bit   e_en1, e_en2, e_data, e_rst;
  int   e_addr;
  logic last_ack;

  function automatic void emit(int a, bit d);
    e_addr = a;
    e_data = d;
    e_en1  = m_sel;
    e_en2  = !m_sel;
  endfunction

  // Applies the inputs present at a clock edge to the model.
  function automatic void model_step();
    int xi, yi;
    if (!reset_n) begin
      m_phase = PH_CLEAR; m_clr = 0; m_sel = 1'b0; m_drop = 0;
      e_en1 = 1'b0; e_en2 = 1'b0; e_addr = 0; e_data = 1'b0; e_rst = 1'b1;
      m_valid = 1'b1;
      return;
    end
    if (!m_valid) return;
    e_rst = 1'b0; e_en1 = 1'b0; e_en2 = 1'b0;
`ifdef FB_DROP_CNT_EN
    if (frame_start && (m_phase == PH_CLEAR || m_phase == PH_DRAW) && m_drop < 255)
      m_drop = m_drop + 1;
`endif
    case (m_phase)
      PH_CLEAR: begin
        emit(m_clr, 1'b0);
        m_clr = m_clr + 1;
        if (m_clr == PIX) begin m_clr = 0; m_phase = PH_DRAW; end
      end
      PH_DRAW: begin
        xi = int'(draw_x);
        yi = int'(draw_y);
        if (draw_req && xi >= 0 && xi < W && yi >= 0 && yi < H)
          emit((yi * W + xi) % (1 << 19), draw_color);
        if (draw_done) m_phase = PH_WAIT;
      end
      PH_WAIT: if (frame_start) m_phase = PH_SWAP;
      default: begin m_sel = !m_sel; m_clr = 0; m_phase = PH_CLEAR; end
    endcase
  endfunction

  // One clock cycle with model checks: ack before the edge, registers after.
  task automatic cyc();
    @(negedge clk);
    last_ack = draw_ack;
    if (m_valid) chk("m_ack", 32'(draw_ack), 32'(draw_req && m_phase == PH_DRAW));
    @(posedge clk);
    model_step();
    #1;
    if (m_valid) begin
      chk("m_en1", 32'(wr_en_fb1), 32'(e_en1));
      chk("m_en2", 32'(wr_en_fb2), 32'(e_en2));
      chk("m_sel", 32'(display_sel), 32'(m_sel));
      chk("m_drop", 32'(drop_cnt), 32'(m_drop));
      if (e_en1 || e_en2 || e_rst) begin
        chk("m_addr", 32'(wr_addr), 32'(e_addr));
        chk("m_data", 32'(wr_data), 32'(e_data));
      end
    end
  endtask

  task automatic idle_inputs();
    frame_start = 1'b0; draw_req = 1'b0; draw_done = 1'b0;
    draw_color = 1'b0; draw_x = '0; draw_y = '0;
  endtask

  typedef struct {
    logic req; int x; int y; logic col;
    logic ack; logic en1; logic en2; int addr; logic data;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int toggles;
    logic prev_sel;
    int xr, yr;

    vecs[0] = '{1'b1,  10,  2, 1'b1, 1'b1, 1'b0, 1'b1, 1290, 1'b1};
    vecs[1] = '{1'b1,  -1,  5, 1'b1, 1'b1, 1'b0, 1'b0,    0, 1'b0};
    vecs[2] = '{1'b1, 640,  0, 1'b1, 1'b1, 1'b0, 1'b0,    0, 1'b0};
    vecs[3] = '{1'b1,   0,  0, 1'b1, 1'b1, 1'b0, 1'b1,    0, 1'b1};
    vecs[4] = '{1'b1, 639,  7, 1'b0, 1'b1, 1'b0, 1'b1, 5119, 1'b0};
    vecs[5] = '{1'b1,   0,  8, 1'b1, 1'b1, 1'b0, 1'b0,    0, 1'b0};
    vecs[6] = '{1'b1,   5, -1, 1'b1, 1'b1, 1'b0, 1'b0,    0, 1'b0};
    vecs[7] = '{1'b0,  20,  3, 1'b1, 1'b0, 1'b0, 1'b0,    0, 1'b0};
    vecs[8] = '{1'b1, 100,  3, 1'b1, 1'b1, 1'b0, 1'b1, 2020, 1'b1};
    vecs[9] = '{1'b1, 639,  0, 1'b1, 1'b1, 1'b0, 1'b1,  639, 1'b1};

    // Reset values
    reset_n = 1'b0;
    repeat (3) cyc();
    chk("rst_addr", 32'(wr_addr), 32'd0);
    chk("rst_data", 32'(wr_data), 32'd0);
    chk("rst_en1", 32'(wr_en_fb1), 32'd0);
    chk("rst_en2", 32'(wr_en_fb2), 32'd0);
    chk("rst_sel", 32'(display_sel), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    draw_req = 1'b1;
    cyc();
    chk("rst_ack", 32'(last_ack), 32'd0);
    draw_req = 1'b0;

    // First clear pass into fb2
    reset_n = 1'b1;
    for (int i = 0; i < PIX; i++) begin
      cyc();
      chk("clr0_en2", 32'(wr_en_fb2), 32'd1);
      chk("clr0_en1", 32'(wr_en_fb1), 32'd0);
      chk("clr0_addr", 32'(wr_addr), 32'(i));
      chk("clr0_data", 32'(wr_data), 32'd0);
    end
    cyc();
    chk("clr0_end_en2", 32'(wr_en_fb2), 32'd0);

    // Table-driven draw requests
    for (int i = 0; i < 10; i++) begin
      draw_req   = vecs[i].req;
      draw_x     = 11'(vecs[i].x);
      draw_y     = 11'(vecs[i].y);
      draw_color = vecs[i].col;
      cyc();
      chk("tbl_ack", 32'(last_ack), 32'(vecs[i].ack));
      chk("tbl_en1", 32'(wr_en_fb1), 32'(vecs[i].en1));
      chk("tbl_en2", 32'(wr_en_fb2), 32'(vecs[i].en2));
      if (vecs[i].en2) begin
        chk("tbl_addr", 32'(wr_addr), 32'(vecs[i].addr));
        chk("tbl_data", 32'(wr_data), 32'(vecs[i].data));
      end
    end
    idle_inputs();
    cyc();

    // frame_start during DRAW: no swap, counted as drops
    repeat (3) begin
      frame_start = 1'b1; cyc();
      frame_start = 1'b0; cyc();
    end
    chk("drop3", 32'(drop_cnt), 32'(DROP3));
    chk("drop_nosel", 32'(display_sel), 32'd0);
    repeat (260) begin frame_start = 1'b1; cyc(); end
    frame_start = 1'b0;
    cyc();
    chk("drop_sat", 32'(drop_cnt), 32'(DROPSAT));

    // draw_done with a simultaneous request: write happens first
    draw_req = 1'b1; draw_x = 11'sd1; draw_y = 11'sd1; draw_color = 1'b1; draw_done = 1'b1;
    cyc();
    chk("done_ack", 32'(last_ack), 32'd1);
    chk("done_en2", 32'(wr_en_fb2), 32'd1);
    chk("done_addr", 32'(wr_addr), 32'd641);
    chk("done_data", 32'(wr_data), 32'd1);
    idle_inputs();

    // Requests ignored while waiting for vblank
    draw_req = 1'b1; draw_x = 11'sd3; draw_y = 11'sd3;
    cyc();
    chk("wait_ack", 32'(last_ack), 32'd0);
    chk("wait_en2", 32'(wr_en_fb2), 32'd0);
    idle_inputs();

    // frame_start 100 cycles after draw_done: exactly one swap
    toggles = 0;
    prev_sel = display_sel;
    for (int i = 0; i < 99; i++) begin
      cyc();
      if (display_sel !== prev_sel) toggles++;
      prev_sel = display_sel;
    end
    frame_start = 1'b1;
    cyc();
    frame_start = 1'b0;
    if (display_sel !== prev_sel) toggles++;
    prev_sel = display_sel;
    cyc();
    if (display_sel !== prev_sel) toggles++;
    prev_sel = display_sel;
    chk("swap_toggles", 32'(toggles), 32'd1);
    chk("swap_sel", 32'(display_sel), 32'd1);

    // Clear into fb1 with stray events; reset at address 5000
    for (int i = 0; i <= 5000; i++) begin
      draw_done   = (i == 100);
      frame_start = (i == 100) || (i == 300);
      draw_req    = (i == 200);
      cyc();
      chk("clr1_en1", 32'(wr_en_fb1), 32'd1);
      chk("clr1_en2", 32'(wr_en_fb2), 32'd0);
      chk("clr1_addr", 32'(wr_addr), 32'(i));
      if (display_sel !== prev_sel) toggles++;
      prev_sel = display_sel;
    end
    idle_inputs();
    chk("clr1_toggles", 32'(toggles), 32'd1);
    reset_n = 1'b0;
    cyc(); cyc();
    chk("rst2_addr", 32'(wr_addr), 32'd0);
    chk("rst2_sel", 32'(display_sel), 32'd0);
    chk("rst2_en1", 32'(wr_en_fb1), 32'd0);
    chk("rst2_drop", 32'(drop_cnt), 32'd0);
    reset_n = 1'b1;
    for (int i = 0; i < PIX; i++) begin
      cyc();
      chk("clr2_en2", 32'(wr_en_fb2), 32'd1);
      chk("clr2_en1", 32'(wr_en_fb1), 32'd0);
      chk("clr2_addr", 32'(wr_addr), 32'(i));
    end

    // Randomized traffic against the model
    for (int i = 0; i < 8000; i++) begin
      xr = int'($urandom_range(660)) - 10;
      yr = int'($urandom_range(12)) - 2;
      draw_req    = ($urandom_range(1) == 1);
      draw_x      = 11'(xr);
      draw_y      = 11'(yr);
      draw_color  = ($urandom_range(1) == 1);
      draw_done   = ($urandom_range(199) == 0);
      frame_start = ($urandom_range(49) == 0);
      reset_n     = ($urandom_range(3999) != 0);
      cyc();
    end
    reset_n = 1'b1;
    idle_inputs();
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fb_swap_ctrl.md
FB_SWAP_CTRL -- requirements
Module: fb_swap_ctrl

Interface
REQ-001 Parameters SHALL be: FB_W, default 640, pixel columns; FB_H, default 480, pixel rows.
REQ-002 Ports SHALL be, clock and reset first:
- clk  input  1  system clock, 50 MHz.
- reset_n  input  1  synchronous, active-low reset.
- frame_start  input  1  one-cycle pulse at VGA line 0.
- draw_req  input  1  drawer pixel-write request.
- draw_x  input  11  signed pixel column.
- draw_y  input  11  signed pixel row.
- draw_color  input  1  pixel value; 1 = white.
- draw_done  input  1  one-cycle pulse: drawer has finished the current frame.
- draw_ack  output  1  request accepted this cycle.
- wr_addr  output  19  write address.
- wr_data  output  1  write data.
- wr_en_fb1  output  1  write enable for buffer 1.
- wr_en_fb2  output  1  write enable for buffer 2.
- display_sel  output  1  buffer shown on VGA: 0 = fb1, 1 = fb2.
- drop_cnt  output  8  missed-swap counter.
REQ-003 Reset SHALL be synchronous and active-low on reset_n; there SHALL be exactly one clock domain, clk.

Function
REQ-004 The FSM SHALL have four states:
- CLEAR: the back buffer is being cleared.
- DRAW: drawer writes are accepted.
- WAIT_SWAP: the frame is complete and waits for vblank.
- SWAP: the buffers exchange roles; this state lasts one cycle.
REQ-005 The back buffer SHALL be the buffer not shown: writes go only to fb2 when display_sel = 0 and only to fb1 when display_sel = 1.
REQ-006 CLEAR behaviour:
- A clear counter runs from 0 to FB_W*FB_H-1, writing wr_data = 0 at one address per cycle.
- After the last address the FSM enters DRAW.
REQ-007 draw_ack SHALL equal draw_req AND (state == DRAW), combinationally.
REQ-008 An accepted request SHALL produce a registered write one cycle later:
- wr_addr = draw_y*FB_W + draw_x, truncated to 19 bits.
- wr_data = draw_color.
- The back-buffer enable is high for that one cycle.
REQ-009 An accepted request with draw_x outside [0, FB_W-1] or draw_y outside [0, FB_H-1] SHALL be acknowledged but produce no write enable.
REQ-010 In DRAW, draw_done SHALL move the FSM to WAIT_SWAP. If draw_req is also high in that cycle, the request is accepted and written first.
REQ-011 In WAIT_SWAP, frame_start SHALL move the FSM to SWAP. In SWAP, display_sel toggles and the FSM enters CLEAR with the clear counter at 0.
REQ-012 Events outside their state SHALL be ignored:
- draw_done outside DRAW.
- frame_start in CLEAR, DRAW or SWAP.
- draw_req outside DRAW; draw_ack stays low.
REQ-013 Both write enables SHALL never be high in the same cycle, and the shown buffer's enable SHALL never be high.
REQ-014 A swap SHALL occur only on a frame_start pulse, so the displayed buffer never changes mid-frame.

Reset
REQ-015 While reset_n = 0 at a clk edge, the block SHALL load the following next cycle:
- state = CLEAR, clear counter = 0, display_sel = 0.
- wr_en_fb1 = wr_en_fb2 = 0, wr_addr = 0, wr_data = 0.
- draw_ack = 0, drop_cnt = 0.
REQ-016 Reset asserted during CLEAR, DRAW or WAIT_SWAP SHALL abort the operation in progress; clearing restarts from address 0 once reset_n returns to 1.

Configuration
REQ-017 With macro FB_DROP_CNT_EN defined:
- drop_cnt increments by 1 on each frame_start seen while state is CLEAR or DRAW.
- drop_cnt saturates at 255.
REQ-018 Without FB_DROP_CNT_EN, drop_cnt SHALL be constant 0 and no counter logic SHALL be synthesized.

Structure
REQ-019 Package fb_pkg SHALL hold:
- FB_W_DEF, FB_H_DEF and FB_ADDR_W = 19.
- State enum fb_state_t {CLEAR, DRAW, WAIT_SWAP, SWAP}.
REQ-020 Address computation SHALL live in sub-module fb_addr_gen:
- Combinational; inputs x, y; outputs addr and in_bounds.
- addr = y*FB_W + x, implemented as (y<<9)+(y<<7)+x when FB_W = 640.

Verification
REQ-021 The bench SHALL cover these scenarios:
- Reset, then 307200 cycles -> wr_en_fb2 high on every cycle, wr_addr steps 0..307199 with wr_data = 0, then state = DRAW and wr_en_fb2 low.
- In DRAW, req x = 10, y = 2, color = 1 -> draw_ack same cycle; next cycle wr_addr = 1290, wr_data = 1, wr_en_fb2 = 1, wr_en_fb1 = 0.
- Req x = -1, y = 5, then x = 640, y = 0 -> draw_ack high both times; no enable ever asserts.
- draw_done then frame_start 100 cycles later -> display_sel goes 0→1 exactly once; the next clear drives wr_en_fb1 only.
- With FB_DROP_CNT_EN, 3 frame_start pulses during DRAW -> drop_cnt = 3; the same test without the macro -> drop_cnt = 0.
- Reset at clear address 5000 -> after release, wr_addr restarts at 0 and display_sel = 0.
